// File: rtl/mux4_rr_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mux4_rr_arbiter_pkg
// Shared definitions for the 4:1 round-robin mux arbiter: requester count,
// select width, FSM state encoding and a select-to-one-hot helper.
// -----------------------------------------------------------------------------
package mux4_rr_arbiter_pkg;

    localparam int NUM_REQ = 4;
    localparam int SEL_W   = 2;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    function automatic logic [NUM_REQ-1:0] sel_to_onehot(input logic [SEL_W-1:0] sel);
        return NUM_REQ'(1) << sel;
    endfunction

endpackage

// File: rtl/mux4_rr_arbiter_if.sv
// -----------------------------------------------------------------------------
// mux4_rr_arbiter_if
// Bundle of the request/data side and the grant/select/data-out side of the
// shared 4:1 mux arbiter.
//   req    [3:0]        request per source, req[k] pairs with ik
//   i0..i3 [DATA_W-1:0] mux data inputs
//   grant  [3:0]        one-hot owner, 0 when idle
//   s1,s0               mux select, index = 2*s1+s0
//   busy                a grant is held
//   o      [DATA_W-1:0] registered mux output
// master: the requesting side; slave: the arbiter.
// -----------------------------------------------------------------------------
interface mux4_rr_arbiter_if
    import mux4_rr_arbiter_pkg::*;
#(
    parameter int DATA_W = 1
);

    logic [NUM_REQ-1:0] req;
    logic [DATA_W-1:0]  i0;
    logic [DATA_W-1:0]  i1;
    logic [DATA_W-1:0]  i2;
    logic [DATA_W-1:0]  i3;
    logic [NUM_REQ-1:0] grant;
    logic               s0;
    logic               s1;
    logic               busy;
    logic [DATA_W-1:0]  o;

    modport master (
        output req, i0, i1, i2, i3,
        input  grant, s0, s1, busy, o
    );

    modport slave (
        input  req, i0, i1, i2, i3,
        output grant, s0, s1, busy, o
    );

endinterface

// File: rtl/mux4_rr_arbiter_rr_pick4.sv
// -----------------------------------------------------------------------------
// rr_pick4
// Combinational rotate-priority picker. Scans i_start, i_start+1, ... (mod 4)
// and returns the first set request.
//   i_req   [3:0]  candidate requests
//   i_start [1:0]  index with highest priority
//   o_any          at least one request set
//   o_idx   [1:0]  winning index (0 when o_any=0)
// -----------------------------------------------------------------------------
module rr_pick4
    import mux4_rr_arbiter_pkg::*;
(
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [SEL_W-1:0]   i_start,
    output logic               o_any,
    output logic [SEL_W-1:0]   o_idx
);

    logic [SEL_W-1:0] w_cand;

    // Walk from lowest to highest priority so the last hit is the winner.
    always_comb begin
        o_any  = 1'b0;
        o_idx  = '0;
        w_cand = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_cand = i_start + SEL_W'(k);
            if (i_req[w_cand]) begin
                o_any = 1'b1;
                o_idx = w_cand;
            end
        end
    end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// -----------------------------------------------------------------------------
// mux4_rr_arbiter
// Round-robin arbiter/sequencer for a shared 4:1 data mux. Owns the mux
// selects, issues a one-hot grant and registers the selected data onto o.
// A single owner keeps the path for at most MAX_HOLD consecutive cycles while
// others wait; with no competition it keeps it indefinitely.
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    slave side of mux4_rr_arbiter_if (req, i0..i3 in; grant, s1, s0,
//          busy, o out). The interface DATA_W must equal this DATA_W.
//
// state    | meaning
// ---------+-----------------------------------------------------------------
// ST_IDLE  | no owner; grant=0, busy=0, o=0, selects hold last value
// ST_GRANT | owner r_sel holds the mux; r_hold counts cycles held beyond first
// -----------------------------------------------------------------------------
module mux4_rr_arbiter
    import mux4_rr_arbiter_pkg::*;
#(
    parameter int DATA_W   = 1,
    parameter int MAX_HOLD = 8
)
(
    input  logic                 clk,
    input  logic                 rst_n,
    mux4_rr_arbiter_if.slave     bus
);

    localparam int              HOLD_W   = $clog2(MAX_HOLD);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD - 1);

    state_t               r_state;
    logic [NUM_REQ-1:0]   r_grant;
    logic [SEL_W-1:0]     r_sel;
    logic                 r_busy;
    logic [HOLD_W-1:0]    r_hold;
    logic [SEL_W-1:0]     r_last;
    logic [DATA_W-1:0]    r_o;

    state_t               w_state_next;
    logic [NUM_REQ-1:0]   w_grant_next;
    logic [SEL_W-1:0]     w_sel_next;
    logic                 w_busy_next;
    logic [HOLD_W-1:0]    w_hold_next;
    logic [SEL_W-1:0]     w_last_next;
    logic [DATA_W-1:0]    w_o_next;

    logic [NUM_REQ-1:0]   w_pick_req;
    logic [SEL_W-1:0]     w_pick_start;
    logic                 w_pick_any;
    logic [SEL_W-1:0]     w_pick_idx;
    logic                 w_owner_keep;
    logic                 w_expire;

    // r_grant is zero in IDLE, so masking the owner out is harmless there and
    // lets one picker serve both the IDLE search and the handover search.
    assign w_pick_req   = bus.req & ~r_grant;
    assign w_pick_start = (r_state == ST_IDLE) ? (r_last + SEL_W'(1)) : (r_sel + SEL_W'(1));
    assign w_owner_keep = |(bus.req & r_grant);
    assign w_expire     = (r_hold == HOLD_MAX) && w_pick_any;

    rr_pick4 u_pick (
        .i_req   (w_pick_req),
        .i_start (w_pick_start),
        .o_any   (w_pick_any),
        .o_idx   (w_pick_idx)
    );

    always_comb begin
        w_state_next = r_state;
        w_grant_next = r_grant;
        w_sel_next   = r_sel;
        w_busy_next  = r_busy;
        w_hold_next  = r_hold;
        w_last_next  = r_last;
        unique case (r_state)
            ST_IDLE: begin
                if (w_pick_any) begin
                    w_state_next = ST_GRANT;
                    w_grant_next = sel_to_onehot(w_pick_idx);
                    w_sel_next   = w_pick_idx;
                    w_busy_next  = 1'b1;
                    w_hold_next  = '0;
                end
            end
            ST_GRANT: begin
                if (!w_owner_keep || w_expire) begin
                    w_last_next = r_sel;
                    if (w_pick_any) begin
                        // Direct handover, no idle cycle in between.
                        w_grant_next = sel_to_onehot(w_pick_idx);
                        w_sel_next   = w_pick_idx;
                        w_hold_next  = '0;
                    end else begin
                        w_state_next = ST_IDLE;
                        w_grant_next = '0;
                        w_busy_next  = 1'b0;
                        w_hold_next  = '0;
                    end
                end else if (r_hold != HOLD_MAX) begin
                    w_hold_next = r_hold + HOLD_W'(1);
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_grant_next = '0;
                w_busy_next  = 1'b0;
                w_hold_next  = '0;
            end
        endcase
    end

    // Output data follows the next select so o lines up with grant.
    always_comb begin
        w_o_next = '0;
        if (w_busy_next) begin
            unique case (w_sel_next)
                2'd0:    w_o_next = bus.i0;
                2'd1:    w_o_next = bus.i1;
                2'd2:    w_o_next = bus.i2;
                default: w_o_next = bus.i3;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_grant <= '0;
            r_sel   <= '0;
            r_busy  <= 1'b0;
            r_hold  <= '0;
            r_last  <= SEL_W'(NUM_REQ - 1);
            r_o     <= '0;
        end else begin
            r_state <= w_state_next;
            r_grant <= w_grant_next;
            r_sel   <= w_sel_next;
            r_busy  <= w_busy_next;
            r_hold  <= w_hold_next;
            r_last  <= w_last_next;
            r_o     <= w_o_next;
        end
    end

    assign bus.grant = r_grant;
    assign bus.s0    = r_sel[0];
    assign bus.s1    = r_sel[1];
    assign bus.busy  = r_busy;
    assign bus.o     = r_o;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mux4_rr_arbiter
// Self-checking bench for mux4_rr_arbiter: a table of directed vectors,
// hand-written multi-cycle sequences and a randomized run against a
// behavioural round-robin model.
// -----------------------------------------------------------------------------
module tb_mux4_rr_arbiter;

    localparam int DW = 4;
    localparam int MH = 8;

    typedef struct {
        logic [3:0]         req;
        logic [3:0][DW-1:0] d;
        logic [3:0]         grant;
        logic [1:0]         sel;
        logic               busy;
        logic [DW-1:0]      o;
    } vec_t;

    logic               clk = 1'b0;
    logic               rst_n = 1'b1;
    logic [3:0]         req;
    logic [3:0][DW-1:0] d;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state: owner index (-1 when idle), rotation pointer,
    // cycles held, and the select value shown on the pins.
    int m_owner;
    int m_last;
    int m_hold;
    int m_sel;

    vec_t tbl [12];

    mux4_rr_arbiter_if #(.DATA_W(DW)) bus ();

    assign bus.req = req;
    assign bus.i0  = d[0];
    assign bus.i1  = d[1];
    assign bus.i2  = d[2];
    assign bus.i3  = d[3];

    mux4_rr_arbiter #(.DATA_W(DW), .MAX_HOLD(MH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic [3:0] rq, input logic [3:0][DW-1:0] dd,
                                input logic [3:0] g, input logic [1:0] s,
                                input logic b, input logic [DW-1:0] oo);
        vec_t v;
        v.req = rq; v.d = dd; v.grant = g; v.sel = s; v.busy = b; v.o = oo;
        return v;
    endfunction

    task automatic check(input string name, input logic [3:0] g, input logic [1:0] s,
                         input logic b, input logic [DW-1:0] oo);
        n_vec++;
        if (bus.grant !== g || {bus.s1, bus.s0} !== s || bus.busy !== b || bus.o !== oo) begin
            n_err++;
            $display("FAIL %s @%0t: got grant=%b sel=%0d busy=%b o=%h, want grant=%b sel=%0d busy=%b o=%h",
                     name, $time, bus.grant, {bus.s1, bus.s0}, bus.busy, bus.o, g, s, b, oo);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int pick(input logic [3:0] rq, input int start);
        for (int k = 0; k < 4; k++) begin
            if (rq[(start + k) % 4]) return (start + k) % 4;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_last  = 3;
        m_hold  = 0;
        m_sel   = 0;
    endtask

    // Advance the model across one rising edge using the current inputs.
    task automatic model_edge();
        int w;
        logic [3:0] others;
        if (m_owner < 0) begin
            w = pick(req, (m_last + 1) % 4);
            if (w >= 0) begin
                m_owner = w; m_sel = w; m_hold = 0;
            end
        end else begin
            others = req;
            others[m_owner] = 1'b0;
            if (!req[m_owner] || (m_hold == MH - 1 && others != 4'b0)) begin
                m_last = m_owner;
                w = pick(others, (m_owner + 1) % 4);
                if (w >= 0) begin
                    m_owner = w; m_sel = w; m_hold = 0;
                end else begin
                    m_owner = -1; m_hold = 0;
                end
            end else if (m_hold < MH - 1) begin
                m_hold++;
            end
        end
    endtask

    task automatic check_model(input string name);
        logic [3:0]    g;
        logic [DW-1:0] oo;
        g  = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0;
        oo = (m_owner >= 0) ? d[m_owner] : '0;
        check(name, g, 2'(m_sel), m_owner >= 0, oo);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = 4'b0;
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        logic [3:0][DW-1:0] dd;
        logic [3:0][DW-1:0] d1;
        dd = {4'hD, 4'hC, 4'hB, 4'hA};
        d1 = {4'h7, 4'h1, 4'h6, 4'h5};

        tbl[0]  = mk(4'b0100, d1, 4'b0100, 2'd2, 1'b1, 4'h1);
        tbl[1]  = mk(4'b0000, dd, 4'b0000, 2'd2, 1'b0, 4'h0);
        tbl[2]  = mk(4'b1111, dd, 4'b1000, 2'd3, 1'b1, 4'hD);
        tbl[3]  = mk(4'b1001, dd, 4'b1000, 2'd3, 1'b1, 4'hD);
        tbl[4]  = mk(4'b0001, dd, 4'b0001, 2'd0, 1'b1, 4'hA);
        tbl[5]  = mk(4'b0110, dd, 4'b0010, 2'd1, 1'b1, 4'hB);
        tbl[6]  = mk(4'b1001, dd, 4'b1000, 2'd3, 1'b1, 4'hD);
        tbl[7]  = mk(4'b0000, dd, 4'b0000, 2'd3, 1'b0, 4'h0);
        tbl[8]  = mk(4'b0011, dd, 4'b0001, 2'd0, 1'b1, 4'hA);
        tbl[9]  = mk(4'b0000, dd, 4'b0000, 2'd0, 1'b0, 4'h0);
        tbl[10] = mk(4'b0011, dd, 4'b0010, 2'd1, 1'b1, 4'hB);
        tbl[11] = mk(4'b0000, dd, 4'b0000, 2'd1, 1'b0, 4'h0);

        req = 4'b1111;
        d   = dd;
        model_reset();

        // Reset asserted with all requests pending.
        #1;
        rst_n = 1'b0;
        #1;
        check("reset_immediate", 4'b0, 2'd0, 1'b0, '0);
        tick();
        check("reset_held", 4'b0, 2'd0, 1'b0, '0);
        do_reset();

        // Directed table.
        for (int i = 0; i < 12; i++) begin
            req = tbl[i].req;
            d   = tbl[i].d;
            tick();
            check($sformatf("table[%0d]", i), tbl[i].grant, tbl[i].sel, tbl[i].busy, tbl[i].o);
        end

        // Full rotation with all requests held.
        do_reset();
        req = 4'b1111;
        d   = dd;
        for (int c = 0; c < 40; c++) begin
            int w;
            tick();
            w = (c / MH) % 4;
            check($sformatf("rotate[%0d]", c), 4'(1 << w), 2'(w), 1'b1, dd[w]);
        end

        // Lone owner saturates, then yields once a competitor appears.
        do_reset();
        req = 4'b0010;
        for (int c = 0; c < 20; c++) begin
            tick();
            check($sformatf("lone[%0d]", c), 4'b0010, 2'd1, 1'b1, 4'hB);
        end
        req = 4'b0011;
        tick();
        check("lone_yield", 4'b0001, 2'd0, 1'b1, 4'hA);

        // Async reset between edges while owner 2 holds the mux.
        do_reset();
        req = 4'b0100;
        tick();
        check("async_pre", 4'b0100, 2'd2, 1'b1, 4'hC);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_drop", 4'b0000, 2'd0, 1'b0, '0);
        #1;
        rst_n = 1'b1;
        req = 4'b0001;
        tick();
        check("async_after", 4'b0001, 2'd0, 1'b1, 4'hA);

        // Randomized run against the model.
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
            d = (4 * DW)'($urandom);
            model_edge();
            tick();
            check_model($sformatf("rand[%0d]", c));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
